// File: rtl/stream_msg_gatherer_if.sv
// rtl/stream_msg_gatherer_if.sv - narrow-beat in / wide-message out bundle for the gatherer
interface stream_msg_gatherer_if #(
  parameter int header_width_p = 64,
  parameter int in_width_p     = 64,
  parameter int max_els_p      = 8
);
  localparam int lg_els_lp = (max_els_p > 1) ? $clog2(max_els_p) : 1;

  logic [header_width_p-1:0]         header_i;
  logic [in_width_p-1:0]             data_i;
  logic [lg_els_lp-1:0]              len_i;
  logic                              v_i;
  logic                              ready_o;
  logic                              len_ready_o;
  logic [header_width_p-1:0]         header_o;
  logic [max_els_p*in_width_p-1:0]   data_o;
  logic                              v_o;
  logic                              yumi_i;

  modport master (
    output header_i, data_i, len_i, v_i, yumi_i,
    input  ready_o, len_ready_o, header_o, data_o, v_o
  );

  modport slave (
    input  header_i, data_i, len_i, v_i, yumi_i,
    output ready_o, len_ready_o, header_o, data_o, v_o
  );
endinterface

// File: rtl/stream_msg_gatherer.sv
// rtl/stream_msg_gatherer.sv - gathers header + N narrow beats into one wide single-beat message
module stream_msg_gatherer #(
  parameter int header_width_p = 64,
  parameter int in_width_p     = 64,
  parameter int max_els_p      = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  stream_msg_gatherer_if.slave   s_if
);
  localparam int lg_els_lp = (max_els_p > 1) ? $clog2(max_els_p) : 1;

  typedef enum logic {ST_FILL = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [lg_els_lp-1:0]            r_count;
  logic [lg_els_lp-1:0]            r_len;
  logic [lg_els_lp-1:0]            w_end_idx;
  logic [header_width_p-1:0]       r_header;
  logic [in_width_p-1:0]           r_data [max_els_p];
  logic [max_els_p*in_width_p-1:0] w_data_flat;
  logic                            w_ready;
  logic                            w_len_ready;
  logic                            w_v;
  logic                            w_accept;
  logic                            w_first;
  logic                            w_last;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= ST_FILL;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_last)      w_state_nxt = ST_HOLD;
      ST_HOLD: if (s_if.yumi_i) w_state_nxt = ST_FILL;
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // ready depends only on state and reset, never on v_i
  always_comb begin
    w_v         = (r_state == ST_HOLD);
    w_ready     = (r_state == ST_FILL) & ~reset_i;
    w_len_ready = w_ready & (r_count == '0);
  end

  assign w_accept  = s_if.v_i & w_ready;
  assign w_first   = w_accept & (r_count == '0);
  assign w_end_idx = (r_count == '0) ? s_if.len_i : r_len;
  assign w_last    = w_accept & ((max_els_p == 1) | (r_count == w_end_idx));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
      r_len   <= '0;
    end else if (w_accept) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
      if (w_first) r_len <= s_if.len_i;
    end
  end

  // first beat wipes the upper slots so a short message never shows stale data
  always_ff @(posedge clk_i) begin
    if (w_first) r_header <= s_if.header_i;
    for (int i = 0; i < max_els_p; i++) begin
      if (w_first)
        r_data[i] <= (i == 0) ? s_if.data_i : '0;
      else if (w_accept && (r_count == lg_els_lp'(i)))
        r_data[i] <= s_if.data_i;
    end
  end

  always_comb begin
    w_data_flat = '0;
    for (int i = 0; i < max_els_p; i++)
      w_data_flat[i*in_width_p +: in_width_p] = r_data[i];
  end

  assign s_if.ready_o     = w_ready;
  assign s_if.len_ready_o = w_len_ready;
  assign s_if.v_o         = w_v;
  assign s_if.header_o    = r_header;
  assign s_if.data_o      = w_data_flat;

  a_len_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    w_first |-> (int'(s_if.len_i) < max_els_p));
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    s_if.yumi_i |-> w_v);
endmodule

// File: tb/tb_stream_msg_gatherer.sv
// tb/tb_stream_msg_gatherer.sv - directed-vector bench for stream_msg_gatherer
module tb_stream_msg_gatherer;
  localparam int HW = 64;
  localparam int IW = 64;
  localparam int NE = 8;

  logic clk_i = 1'b0;
  logic reset_i;
  int   n_vec = 0;
  int   n_err = 0;
  logic [511:0] exp_data;

  always #5 clk_i = ~clk_i;

  stream_msg_gatherer_if #(.header_width_p(HW), .in_width_p(IW), .max_els_p(NE)) u_if ();

  stream_msg_gatherer #(.header_width_p(HW), .in_width_p(IW), .max_els_p(NE)) u_dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .s_if    (u_if)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // present one beat at a negedge, leave it for exactly one rising edge
  task automatic beat(input logic [63:0] h, input logic [63:0] d, input logic [2:0] l);
    u_if.header_i = h;
    u_if.data_i   = d;
    u_if.len_i    = l;
    u_if.v_i      = 1'b1;
    @(negedge clk_i);
    u_if.v_i      = 1'b0;
  endtask

  task automatic dequeue(input string tag);
    u_if.yumi_i = 1'b1;
    @(negedge clk_i);
    u_if.yumi_i = 1'b0;
    check({tag, "_vo_after_yumi"}, u_if.v_o, 1'b0);
    check({tag, "_rdy_after_yumi"}, u_if.ready_o, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i       = 1'b1;
    u_if.header_i = '0;
    u_if.data_i   = '0;
    u_if.len_i    = '0;
    u_if.v_i      = 1'b0;
    u_if.yumi_i   = 1'b0;

    @(negedge clk_i);
    check("rst_rdy", u_if.ready_o, 1'b0);
    check("rst_lenrdy", u_if.len_ready_o, 1'b0);
    check("rst_vo", u_if.v_o, 1'b0);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_rdy", u_if.ready_o, 1'b1);
    check("post_rst_lenrdy", u_if.len_ready_o, 1'b1);

    // single-beat message
    beat(64'hA5, 64'h11, 3'd0);
    check("single_vo", u_if.v_o, 1'b1);
    check("single_hdr", u_if.header_o, 64'hA5);
    check("single_data", u_if.data_o, 512'h11);
    check("single_rdy", u_if.ready_o, 1'b0);
    dequeue("single");

    // full-length message; later len/header must be ignored
    exp_data = '0;
    for (int i = 0; i < 8; i++) begin
      beat((i == 0) ? 64'hBEEF : 64'hDEAD0 + 64'(i), 64'(i), (i == 0) ? 3'd7 : 3'(i - 1));
      exp_data[i*64 +: 64] = 64'(i);
      if (i == 6) check("full_vo_early", u_if.v_o, 1'b0);
      if (i == 3) check("full_lenrdy_mid", u_if.len_ready_o, 1'b0);
    end
    check("full_vo", u_if.v_o, 1'b1);
    check("full_hdr", u_if.header_o, 64'hBEEF);
    check("full_data", u_if.data_o, exp_data);
    dequeue("full");

    // stalled input, then stalled output with v_i held high (handshake corner)
    exp_data = '0;
    for (int i = 0; i < 4; i++) begin
      beat((i == 0) ? 64'h7777 : 64'h0, 64'hC0 + 64'(i), 3'd3);
      exp_data[i*64 +: 64] = 64'hC0 + 64'(i);
      if (i < 3) begin
        repeat (2) @(negedge clk_i);
        check("stall_vo_gap", u_if.v_o, 1'b0);
      end
    end
    check("stall_vo", u_if.v_o, 1'b1);
    u_if.header_i = 64'h99;
    u_if.data_i   = 64'h77;
    u_if.len_i    = 3'd0;
    u_if.v_i      = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check("hold_vo", u_if.v_o, 1'b1);
      check("hold_rdy", u_if.ready_o, 1'b0);
      check("hold_hdr", u_if.header_o, 64'h7777);
      check("hold_data", u_if.data_o, exp_data);
    end
    u_if.yumi_i = 1'b1;
    @(negedge clk_i);
    u_if.yumi_i = 1'b0;
    check("corner_vo", u_if.v_o, 1'b0);
    check("corner_lenrdy", u_if.len_ready_o, 1'b1);
    @(negedge clk_i);
    u_if.v_i = 1'b0;
    check("corner_vo2", u_if.v_o, 1'b1);
    check("corner_hdr", u_if.header_o, 64'h99);
    check("corner_data", u_if.data_o, 512'h77);
    dequeue("corner");

    // back-to-back: A (len 1), then B offered during A's yumi cycle
    beat(64'h1, 64'hAAAA, 3'd1);
    beat(64'h2, 64'hBBBB, 3'd5);
    exp_data = '0;
    exp_data[63:0]   = 64'hAAAA;
    exp_data[127:64] = 64'hBBBB;
    check("a_vo", u_if.v_o, 1'b1);
    check("a_hdr", u_if.header_o, 64'h1);
    check("a_data", u_if.data_o, exp_data);
    u_if.header_i = 64'h3C;
    u_if.data_i   = 64'hCC;
    u_if.len_i    = 3'd0;
    u_if.v_i      = 1'b1;
    u_if.yumi_i   = 1'b1;
    @(negedge clk_i);
    u_if.yumi_i = 1'b0;
    check("b_not_bypassed", u_if.v_o, 1'b0);
    check("b_rdy", u_if.ready_o, 1'b1);
    @(negedge clk_i);
    u_if.v_i = 1'b0;
    check("b_vo", u_if.v_o, 1'b1);
    check("b_hdr", u_if.header_o, 64'h3C);
    check("b_data", u_if.data_o, 512'hCC);
    dequeue("b");

    // asynchronous reset mid-message
    beat(64'hF0, 64'hE0, 3'd5);
    beat(64'h0, 64'hE1, 3'd0);
    beat(64'h0, 64'hE2, 3'd0);
    #2 reset_i = 1'b1;
    #1;
    check("mid_rst_rdy", u_if.ready_o, 1'b0);
    check("mid_rst_lenrdy", u_if.len_ready_o, 1'b0);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    check("after_rst_vo", u_if.v_o, 1'b0);
    check("after_rst_lenrdy", u_if.len_ready_o, 1'b1);
    beat(64'h55, 64'h99, 3'd0);
    check("new_vo", u_if.v_o, 1'b1);
    check("new_hdr", u_if.header_o, 64'h55);
    check("new_data", u_if.data_o, 512'h99);
    dequeue("new");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
